// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, oversampling constants and default baud divisor.
package uart_pkg;
    localparam int OVERSAMPLE       = 16;
    localparam int MID_SAMPLE       = 7;
    localparam int DEFAULT_BAUD_DIV = 54;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick, one clk wide every BAUD_DIV cycles.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    logic [CW-1:0] r_cnt;
    assign tick = r_cnt == CW'(BAUD_DIV - 1);
    always_ff @(posedge clk) begin
        r_cnt <= (rst || tick) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x oversampling UART receiver, 8N1 LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int SW = $clog2(SB_TICKS > OVERSAMPLE ? SB_TICKS : OVERSAMPLE);
    localparam int NW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;

    logic [1:0]           r_sync;
    logic                 w_rxs, w_tick, w_par_ok;
    state_t               r_state, w_state_next;
    logic [SW-1:0]        r_s, w_s_next;
    logic [NW-1:0]        r_n, w_n_next;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_next, r_data, w_data_next;
    logic                 r_done, w_done_next, r_ferr, w_ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_next, r_perr, w_perr_next;
    assign w_par_ok   = r_par == ^r_shreg;
    assign parity_err = r_perr;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign w_rxs        = r_sync[1];
    assign rx_data      = r_data;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (.clk(clk), .rst(rst), .tick(w_tick));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_shreg <= w_shreg_next;
            r_data  <= w_data_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_next;
            r_perr  <= w_perr_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_shreg_next = r_shreg;
        w_data_next  = r_data;
        w_done_next  = 1'b0;
        w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_next   = r_par;
        w_perr_next  = 1'b0;
`endif
        case (r_state)
            IDLE: if (!w_rxs) begin
                w_s_next     = '0;
                w_state_next = START;
            end
            START: if (w_tick) begin
                if (r_s == SW'(MID_SAMPLE)) begin
                    w_s_next     = '0;
                    w_n_next     = '0;
                    w_state_next = w_rxs ? IDLE : DATA;
                end else w_s_next = r_s + 1'b1;
            end
            DATA: if (w_tick) begin
                if (r_s == SW'(OVERSAMPLE - 1)) begin
                    w_s_next     = '0;
                    w_shreg_next = {w_rxs, r_shreg[DATA_BITS-1:1]};
                    if (r_n == NW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    else w_n_next = r_n + 1'b1;
                end else w_s_next = r_s + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_tick) begin
                if (r_s == SW'(OVERSAMPLE - 1)) begin
                    w_s_next     = '0;
                    w_par_next   = w_rxs;
                    w_state_next = STOP;
                end else w_s_next = r_s + 1'b1;
            end
`endif
            STOP: if (w_tick) begin
                if (r_s == SW'(SB_TICKS - 1)) begin
                    w_s_next     = '0;
                    w_state_next = IDLE;
                    // a bad stop bit outranks a parity fault
                    if (!w_rxs) w_ferr_next = 1'b1;
                    else if (w_par_ok) begin
                        w_done_next = 1'b1;
                        w_data_next = r_shreg;
                    end
`ifdef UART_RX_PARITY_EN
                    else w_perr_next = 1'b1;
`endif
                end else w_s_next = r_s + 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame at BAUD_DIV=4.
// Define UART_RX_PARITY_EN to also exercise the parity frames.
module tb_uart_rx_frame;
    localparam int BD  = 4;
    localparam int BIT = BD * 16;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_FERR = 2'd2;
    localparam logic [1:0] EV_PERR = 2'd3;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done_tick, frame_err, parity_err;
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_checks = 0;
    int         n_pass = 0;

    uart_rx_frame #(.BAUD_DIV(BD), .DATA_BITS(8), .SB_TICKS(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
        .rx_done_tick(rx_done_tick), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done_tick) obs_q.push_back({EV_DONE, rx_data});
        if (frame_err)    obs_q.push_back({EV_FERR, rx_data});
        if (parity_err)   obs_q.push_back({EV_PERR, rx_data});
    end

    task automatic send_bit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
        if (!stop_ok) exp_q.push_back({EV_FERR, last_good});
        else if (PAR_EN && par_flip) exp_q.push_back({EV_PERR, last_good});
        else begin
            exp_q.push_back({EV_DONE, d});
            last_good = d;
        end
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
        if (PAR_EN) send_bit(^d ^ par_flip, BIT);
        if (stop_ok) send_bit(1'b1, BIT);
        else begin
            // release the line soon after mid-stop so the tail reads as a glitch
            send_bit(1'b0, BIT * 11 / 16);
            send_bit(1'b1, BIT * 5 / 16);
        end
    endtask

    task automatic wait_events();
        for (int i = 0; i < BIT * 4 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (rx_done_tick !== 1'b0) $display("FAIL reset_done: got %b expected 0", rx_done_tick); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else n_pass++;
        n_checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b expected 0", parity_err); else n_pass++;
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic stop_ok, input logic par_flip);
        logic [9:0] o, e;
        send_frame(d, stop_ok, par_flip);
        wait_events();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL %s_count: got %0d events expected %0d", name, obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s_event: got kind %0d data %h expected kind %0d data %h", name, o[9:8], o[7:0], e[9:8], e[7:0]);
            else n_pass++;
        end
        obs_q.delete();
        exp_q.delete();
        n_checks++; if (rx_data !== last_good) $display("FAIL %s_hold: got %h expected %h", name, rx_data, last_good); else n_pass++;
    endtask

    task automatic test_glitch();
        send_bit(1'b0, BD * 4);
        send_bit(1'b1, BIT * 2);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL glitch_count: got %0d events expected 0", obs_q.size()); else n_pass++;
        n_checks++; if (rx_data !== last_good) $display("FAIL glitch_hold: got %h expected %h", rx_data, last_good); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [9:0] o, e;
        send_frame(8'h73, 1'b1, 1'b0);
        send_frame(8'h64, 1'b1, 1'b0);
        wait_events();
        n_checks++;
        if (obs_q.size() !== 2) $display("FAIL b2b_count: got %0d events expected 2", obs_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL b2b_event: got kind %0d data %h expected kind %0d data %h", o[9:8], o[7:0], e[9:8], e[7:0]);
            else n_pass++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'h20;
        send_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) send_bit(d[i], BIT);
        rx = d[3];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        send_bit(1'b1, BIT * 3);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL rstmid_count: got %0d events expected 0", obs_q.size()); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", rx_data); else n_pass++;
        obs_q.delete();
        test_frame("rstmid_fresh", 8'h20, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame("good_77", 8'h77, 1'b1, 1'b0);
        test_glitch();
        test_frame("ferr_61", 8'h61, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_frame("perr_77", 8'h77, 1'b1, 1'b1);
        test_frame("par_ok_77", 8'h77, 1'b1, 1'b0);
        test_frame("par_ferr_5a", 8'h5a, 1'b0, 1'b1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
